// File: rtl/ofdm_frame_sequencer.sv
// ofdm_frame_sequencer
//   Steps one OFDM frame through PREAMBLE -> FCH -> DATA -> GAP and back to
//   IDLE, counting accepted samples per section and data symbols per frame.
//
// Ports
//   i_clk              : clock, all logic on the rising edge
//   i_reset_n          : asynchronous active-low reset
//   i_start            : frame request, honoured only in IDLE
//   i_data_frame_size  : data symbols in the requested frame
//   i_ready            : downstream takes one sample this cycle
//   i_abort            : drop the current frame immediately
//   o_preamble_frame   : high while in PREAMBLE
//   o_fch_frame        : high while in FCH
//   o_data_frame       : high while in DATA
//   o_sample_cnt       : accepted-sample index in the section (cycle index in GAP)
//   o_symbol_cnt       : data symbol index, 0 outside DATA
//   o_frame_size       : data symbol count latched at frame start
//   o_busy             : high in any state but IDLE
//   o_done             : one-cycle pulse on normal frame completion
module ofdm_frame_sequencer #(
  parameter int unsigned PREAMBLE_LEN = 320,
  parameter int unsigned FCH_LEN      = 80,
  parameter int unsigned SYMBOL_LEN   = 80,
  parameter int unsigned GAP_LEN      = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic [7:0]  i_data_frame_size,
  input  logic        i_ready,
  input  logic        i_abort,
  output logic        o_preamble_frame,
  output logic        o_fch_frame,
  output logic        o_data_frame,
  output logic [15:0] o_sample_cnt,
  output logic [7:0]  o_symbol_cnt,
  output logic [7:0]  o_frame_size,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_FCH      = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;

  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] FCH_LAST = 16'(FCH_LEN - 1);
  localparam logic [15:0] SYM_LAST = 16'(SYMBOL_LEN - 1);
  localparam logic [15:0] GAP_LAST = 16'((GAP_LEN == 0) ? 0 : GAP_LEN - 1);

  // With no guard interval the last payload sample finishes the frame directly.
  localparam logic       NO_GAP     = (GAP_LEN == 0);
  localparam logic [2:0] ST_PAYLOAD_END = NO_GAP ? ST_IDLE : ST_GAP;

  logic [1:0]  run_sync_reg;
  logic [2:0]  state_reg, state_next;
  logic [15:0] sample_cnt_reg, sample_cnt_next;
  logic [7:0]  symbol_cnt_reg, symbol_cnt_next;
  logic [7:0]  frame_size_reg, frame_size_next;
  logic        done_reg, done_next;
  logic        preamble_reg, fch_reg, data_reg, busy_reg;

  // Reset is released into the FSM through two flops; until the second one
  // sets, i_start is ignored, so a start coinciding with (or racing) the
  // release edge can never launch a frame.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      run_sync_reg <= 2'b00;
    end else begin
      run_sync_reg <= {run_sync_reg[0], 1'b1};
    end
  end

  always_comb begin
    state_next      = state_reg;
    sample_cnt_next = sample_cnt_reg;
    symbol_cnt_next = symbol_cnt_reg;
    frame_size_next = frame_size_reg;
    done_next       = 1'b0;

    if (state_reg != ST_IDLE && i_abort) begin
      // Abort takes priority over any section end in the same cycle.
      state_next      = ST_IDLE;
      sample_cnt_next = '0;
      symbol_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          sample_cnt_next = '0;
          symbol_cnt_next = '0;
          if (run_sync_reg[1] && i_start && !i_abort) begin
            state_next      = ST_PREAMBLE;
            frame_size_next = i_data_frame_size;
          end
        end
        ST_PREAMBLE: begin
          if (i_ready) begin
            if (sample_cnt_reg == PRE_LAST) begin
              sample_cnt_next = '0;
              state_next      = ST_FCH;
            end else begin
              sample_cnt_next = sample_cnt_reg + 16'd1;
            end
          end
        end
        ST_FCH: begin
          if (i_ready) begin
            if (sample_cnt_reg == FCH_LAST) begin
              sample_cnt_next = '0;
              if (frame_size_reg != 8'd0) begin
                state_next = ST_DATA;
              end else begin
                state_next = ST_PAYLOAD_END;
                done_next  = NO_GAP;
              end
            end else begin
              sample_cnt_next = sample_cnt_reg + 16'd1;
            end
          end
        end
        ST_DATA: begin
          if (i_ready) begin
            if (sample_cnt_reg == SYM_LAST) begin
              sample_cnt_next = '0;
              if (symbol_cnt_reg == frame_size_reg - 8'd1) begin
                symbol_cnt_next = '0;
                state_next      = ST_PAYLOAD_END;
                done_next       = NO_GAP;
              end else begin
                symbol_cnt_next = symbol_cnt_reg + 8'd1;
              end
            end else begin
              sample_cnt_next = sample_cnt_reg + 16'd1;
            end
          end
        end
        ST_GAP: begin
          // Guard counts clock cycles, not accepted samples.
          if (sample_cnt_reg == GAP_LAST) begin
            sample_cnt_next = '0;
            state_next      = ST_IDLE;
            done_next       = 1'b1;
          end else begin
            sample_cnt_next = sample_cnt_reg + 16'd1;
          end
        end
        default: begin
          state_next      = ST_IDLE;
          sample_cnt_next = '0;
          symbol_cnt_next = '0;
        end
      endcase
    end
  end

  // Strobes and busy are decoded from the next state so they are flops that
  // line up exactly with state_reg.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg      <= ST_IDLE;
      sample_cnt_reg <= '0;
      symbol_cnt_reg <= '0;
      frame_size_reg <= '0;
      done_reg       <= 1'b0;
      preamble_reg   <= 1'b0;
      fch_reg        <= 1'b0;
      data_reg       <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sample_cnt_reg <= sample_cnt_next;
      symbol_cnt_reg <= symbol_cnt_next;
      frame_size_reg <= frame_size_next;
      done_reg       <= done_next;
      preamble_reg   <= (state_next == ST_PREAMBLE);
      fch_reg        <= (state_next == ST_FCH);
      data_reg       <= (state_next == ST_DATA);
      busy_reg       <= (state_next != ST_IDLE);
    end
  end

  assign o_preamble_frame = preamble_reg;
  assign o_fch_frame      = fch_reg;
  assign o_data_frame     = data_reg;
  assign o_sample_cnt     = sample_cnt_reg;
  assign o_symbol_cnt     = symbol_cnt_reg;
  assign o_frame_size     = frame_size_reg;
  assign o_busy           = busy_reg;
  assign o_done           = done_reg;

endmodule

// File: tb/tb_ofdm_frame_sequencer.sv
module tb_ofdm_frame_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  size;
  logic        ready;
  logic        abort;

  logic        pre, fch, dat, busy, done;
  logic [15:0] scnt;
  logic [7:0]  sym, fsize;
  logic        pre0, fch0, dat0, busy0, done0;
  logic [15:0] scnt0;
  logic [7:0]  sym0, fsize0;

  int checks = 0;
  int errors = 0;

  ofdm_frame_sequencer #(
    .PREAMBLE_LEN(4), .FCH_LEN(2), .SYMBOL_LEN(3), .GAP_LEN(2)
  ) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_data_frame_size(size),
    .i_ready(ready), .i_abort(abort),
    .o_preamble_frame(pre), .o_fch_frame(fch), .o_data_frame(dat),
    .o_sample_cnt(scnt), .o_symbol_cnt(sym), .o_frame_size(fsize),
    .o_busy(busy), .o_done(done)
  );

  ofdm_frame_sequencer #(
    .PREAMBLE_LEN(4), .FCH_LEN(2), .SYMBOL_LEN(3), .GAP_LEN(0)
  ) u_dut_nogap (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_data_frame_size(size),
    .i_ready(ready), .i_abort(abort),
    .o_preamble_frame(pre0), .o_fch_frame(fch0), .o_data_frame(dat0),
    .o_sample_cnt(scnt0), .o_symbol_cnt(sym0), .o_frame_size(fsize0),
    .o_busy(busy0), .o_done(done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; size = 8'd0; ready = 1'b0; abort = 1'b0;
    repeat (2) tick();
    checks++; if ({pre, fch, dat} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {pre, fch, dat}); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    checks++; if (scnt !== 16'd0 || sym !== 8'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", scnt, sym); end
    checks++; if (fsize !== 8'd0) begin errors++; $display("FAIL reset_fsize: got %0d expected 0", fsize); end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_after_release: got %b expected 0", busy); end
    $display("test_reset: busy=%b fsize=%0d", busy, fsize);
  endtask

  task automatic test_normal();
    logic [2:0] exp_sec [15];
    int exp_scnt [15];
    int exp_sym [15];
    exp_sec  = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
    exp_scnt = '{0, 1, 2, 3, 0, 1, 0, 1, 2, 0, 1, 2, 0, 1, 0};
    exp_sym  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    size = 8'd2; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      $display("normal cyc %0d sec=%b scnt=%0d sym=%0d busy=%b done=%b", i, {pre, fch, dat}, scnt, sym, busy, done);
      checks++; if ({pre, fch, dat} !== exp_sec[i]) begin errors++; $display("FAIL normal_strobes[%0d]: got %b expected %b", i, {pre, fch, dat}, exp_sec[i]); end
      checks++; if (scnt !== 16'(exp_scnt[i])) begin errors++; $display("FAIL normal_scnt[%0d]: got %0d expected %0d", i, scnt, exp_scnt[i]); end
      checks++; if (sym !== 8'(exp_sym[i])) begin errors++; $display("FAIL normal_sym[%0d]: got %0d expected %0d", i, sym, exp_sym[i]); end
      checks++; if (busy !== (i < 14)) begin errors++; $display("FAIL normal_busy[%0d]: got %b expected %b", i, busy, (i < 14)); end
      checks++; if (done !== (i == 14)) begin errors++; $display("FAIL normal_done[%0d]: got %b expected %b", i, done, (i == 14)); end
      tick();
    end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL normal_done_pulse: got %b expected 0", done); end
    checks++; if (fsize !== 8'd2) begin errors++; $display("FAIL normal_fsize: got %0d expected 2", fsize); end
  endtask

  task automatic test_ready_toggle();
    int n_pre = 0, n_fch = 0, n_dat = 0, n_acc = 0, n_gap = 0, n_done = 0, n_busy = 0;
    logic [2:0] prev_sec;
    logic [15:0] prev_scnt;
    logic prev_ready;
    size = 8'd2; ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    prev_sec = 3'd0; prev_scnt = 16'd0; prev_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      ready = (i % 2 == 1);
      if (pre) n_pre++;
      if (fch) n_fch++;
      if (dat) n_dat++;
      if ((pre || fch || dat) && ready) n_acc++;
      if (busy && !(pre || fch || dat)) n_gap++;
      if (done) n_done++;
      if (busy) n_busy++;
      if ({pre, fch, dat} != 3'd0 && {pre, fch, dat} == prev_sec && !prev_ready) begin
        checks++; if (scnt !== prev_scnt) begin errors++; $display("FAIL toggle_hold[%0d]: got %0d expected %0d", i, scnt, prev_scnt); end
      end
      prev_sec = {pre, fch, dat}; prev_scnt = scnt; prev_ready = ready;
      tick();
    end
    ready = 1'b1;
    $display("toggle: pre=%0d fch=%0d data=%0d acc=%0d gap=%0d done=%0d busy=%0d", n_pre, n_fch, n_dat, n_acc, n_gap, n_done, n_busy);
    checks++; if (n_pre !== 8) begin errors++; $display("FAIL toggle_pre_cycles: got %0d expected 8", n_pre); end
    checks++; if (n_fch !== 4) begin errors++; $display("FAIL toggle_fch_cycles: got %0d expected 4", n_fch); end
    checks++; if (n_dat !== 12) begin errors++; $display("FAIL toggle_data_cycles: got %0d expected 12", n_dat); end
    checks++; if (n_acc !== 12) begin errors++; $display("FAIL toggle_accepted: got %0d expected 12", n_acc); end
    checks++; if (n_gap !== 2) begin errors++; $display("FAIL toggle_gap_cycles: got %0d expected 2", n_gap); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL toggle_done_count: got %0d expected 1", n_done); end
    checks++; if (n_busy !== 26) begin errors++; $display("FAIL toggle_busy_cycles: got %0d expected 26", n_busy); end
  endtask

  task automatic test_size_zero();
    int n_pre = 0, n_fch = 0, n_dat = 0, n_gap = 0, n_done = 0, n_busy = 0;
    size = 8'd0; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (pre) n_pre++;
      if (fch) n_fch++;
      if (dat) n_dat++;
      if (busy && !(pre || fch || dat)) n_gap++;
      if (done) n_done++;
      if (busy) n_busy++;
      tick();
    end
    $display("size0: pre=%0d fch=%0d data=%0d gap=%0d done=%0d busy=%0d", n_pre, n_fch, n_dat, n_gap, n_done, n_busy);
    checks++; if (n_pre !== 4 || n_fch !== 2) begin errors++; $display("FAIL size0_pre_fch: got %0d/%0d expected 4/2", n_pre, n_fch); end
    checks++; if (n_dat !== 0) begin errors++; $display("FAIL size0_data_cycles: got %0d expected 0", n_dat); end
    checks++; if (n_gap !== 2) begin errors++; $display("FAIL size0_gap_cycles: got %0d expected 2", n_gap); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL size0_done_count: got %0d expected 1", n_done); end
    checks++; if (n_busy !== 8) begin errors++; $display("FAIL size0_busy_cycles: got %0d expected 8", n_busy); end
    checks++; if (fsize !== 8'd0) begin errors++; $display("FAIL size0_fsize: got %0d expected 0", fsize); end
  endtask

  task automatic test_abort();
    size = 8'd2; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    checks++; if (dat !== 1'b1 || sym !== 8'd1 || scnt !== 16'd0) begin errors++; $display("FAIL abort_setup: got data=%b sym=%0d scnt=%0d expected 1/1/0", dat, sym, scnt); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    $display("abort: busy=%b sec=%b scnt=%0d sym=%0d done=%b", busy, {pre, fch, dat}, scnt, sym, done);
    checks++; if (busy !== 1'b0 || {pre, fch, dat} !== 3'b000) begin errors++; $display("FAIL abort_idle: got busy=%b sec=%b expected 0/000", busy, {pre, fch, dat}); end
    checks++; if (scnt !== 16'd0 || sym !== 8'd0) begin errors++; $display("FAIL abort_counters: got %0d/%0d expected 0/0", scnt, sym); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done); end
    size = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (pre !== 1'b1 || fsize !== 8'd3) begin errors++; $display("FAIL abort_restart: got pre=%b fsize=%0d expected 1/3", pre, fsize); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_cleanup: got busy=%b done=%b expected 0/0", busy, done); end
    checks++; if (fsize !== 8'd3) begin errors++; $display("FAIL abort_fsize_hold: got %0d expected 3", fsize); end
  endtask

  task automatic test_reset_mid();
    size = 8'd2; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    tick();
    checks++; if (fch !== 1'b1 || scnt !== 16'd1) begin errors++; $display("FAIL busy_start_ignored: got fch=%b scnt=%0d expected 1/1", fch, scnt); end
    #2 rst_n = 1'b0;
    #1;
    $display("reset_mid: busy=%b sec=%b scnt=%0d fsize=%0d", busy, {pre, fch, dat}, scnt, fsize);
    checks++; if (busy !== 1'b0 || {pre, fch, dat} !== 3'b000 || done !== 1'b0) begin errors++; $display("FAIL midreset_async: got busy=%b sec=%b done=%b expected 0/000/0", busy, {pre, fch, dat}, done); end
    checks++; if (scnt !== 16'd0 || fsize !== 8'd0) begin errors++; $display("FAIL midreset_counters: got %0d/%0d expected 0/0", scnt, fsize); end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || pre !== 1'b0) begin errors++; $display("FAIL release_start_ignored: got busy=%b pre=%b expected 0/0", busy, pre); end
    start = 1'b0;
    repeat (3) tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_no_done: got done=%b busy=%b expected 0/0", done, busy); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (pre !== 1'b1) begin errors++; $display("FAIL midreset_restart: got %b expected 1", pre); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_gap_zero();
    int n_dat = 0, n_done = 0, done_at = -1;
    size = 8'd1; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (dat0) n_dat++;
      if (done0) begin n_done++; done_at = i; end
      if (i == 8) begin
        checks++; if (dat0 !== 1'b1 || scnt0 !== 16'd2) begin errors++; $display("FAIL gap0_last_sample: got data=%b scnt=%0d expected 1/2", dat0, scnt0); end
      end
      if (i == 9) begin
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL gap0_idle: got busy=%b expected 0", busy0); end
      end
      tick();
    end
    $display("gap0: data=%0d done=%0d done_at=%0d", n_dat, n_done, done_at);
    checks++; if (n_dat !== 3) begin errors++; $display("FAIL gap0_data_cycles: got %0d expected 3", n_dat); end
    checks++; if (n_done !== 1 || done_at !== 9) begin errors++; $display("FAIL gap0_done: got count=%0d at=%0d expected 1 at 9", n_done, done_at); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; size = 8'd0; ready = 1'b0; abort = 1'b0;
    test_reset();
    test_normal();
    repeat (3) tick();
    test_ready_toggle();
    repeat (3) tick();
    test_size_zero();
    repeat (3) tick();
    test_abort();
    repeat (3) tick();
    test_reset_mid();
    repeat (3) tick();
    test_gap_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofdm_frame_sequencer.md
OFDM_FRAME_SEQUENCER -- requirements
Module: ofdm_frame_sequencer

Interface
REQ-001 Parameter PREAMBLE_LEN, default 320: preamble length in samples (1..65535).
REQ-002 Parameter FCH_LEN, default 80: FCH length in samples (1..65535).
REQ-003 Parameter SYMBOL_LEN, default 80: data symbol length in samples, cyclic prefix included (1..65535).
REQ-004 Parameter GAP_LEN, default 16: inter-frame guard in clock cycles (0..65535).
REQ-005 i_clk  in  1  single clock; all logic on its rising edge.
REQ-006 i_reset_n  in  1  asynchronous, active-low reset.
REQ-007 i_start  in  1  frame request; sampled in IDLE only.
REQ-008 i_data_frame_size  in  8  data symbols per frame; captured on accepted i_start.
REQ-009 i_ready  in  1  downstream accepts one sample this cycle.
REQ-010 i_abort  in  1  terminate current frame.
REQ-011 o_preamble_frame  out  1  high while in PREAMBLE.
REQ-012 o_fch_frame  out  1  high while in FCH; drives FCH generator frame input.
REQ-013 o_data_frame  out  1  high while in DATA.
REQ-014 o_sample_cnt  out  16  accepted-sample index within current section.
REQ-015 o_symbol_cnt  out  8  current data symbol index.
REQ-016 o_frame_size  out  8  latched i_data_frame_size.
REQ-017 o_busy  out  1  high in any state except IDLE.
REQ-018 o_done  out  1  one-cycle pulse on normal frame completion.

Function
REQ-019 States: IDLE, PREAMBLE, FCH, DATA, GAP; all outputs registered.
REQ-020 o_preamble_frame, o_fch_frame, o_data_frame are one-hot-or-zero, decoded from state.
REQ-021 IDLE, i_start=1, i_abort=0 -> PREAMBLE next cycle; latch o_frame_size; clear both counters.
REQ-022 i_start outside IDLE is ignored; i_start and i_abort together in IDLE -> stay IDLE.
REQ-023 In PREAMBLE/FCH/DATA, o_sample_cnt increments by 1 only on cycles with i_ready=1; holds otherwise.
REQ-024 Section ends on the accepted sample where o_sample_cnt = LEN-1; next cycle o_sample_cnt = 0 and the next state is entered.
REQ-025 PREAMBLE end -> FCH.
REQ-026 FCH end -> DATA if o_frame_size != 0, else GAP.
REQ-027 DATA symbol end: if o_symbol_cnt = o_frame_size-1 -> GAP, o_symbol_cnt cleared; else o_symbol_cnt increments and stays DATA.
REQ-028 GAP counts clock cycles independent of i_ready, using o_sample_cnt; after GAP_LEN cycles -> IDLE with o_done=1 on that IDLE entry cycle.
REQ-029 GAP_LEN=0: FCH/DATA end goes directly to IDLE with o_done=1, skipping GAP.
REQ-030 Total accepted samples per frame = PREAMBLE_LEN + FCH_LEN + o_frame_size*SYMBOL_LEN.
REQ-031 i_abort=1 in any non-IDLE state -> IDLE next cycle, counters cleared, o_done stays 0; abort wins over simultaneous section end.
REQ-032 o_symbol_cnt is 0 outside DATA; o_sample_cnt is 0 in IDLE.
REQ-033 Counters never wrap: section-end comparison precedes increment.
REQ-034 o_frame_size holds its value until next accepted i_start.

Reset
REQ-035 i_reset_n low asynchronously forces IDLE, all counters 0, o_frame_size 0, all frame strobes, o_busy, o_done 0.
REQ-036 Reset asserted mid-frame discards the frame; no o_done; first cycle after release is IDLE.
REQ-037 Reset release is synchronised to i_clk; i_start on the release edge is ignored.

Verification
REQ-038 PREAMBLE_LEN=4, FCH_LEN=2, SYMBOL_LEN=3, GAP_LEN=2, size=2, i_ready=1 -> strobes 4/2/6 cycles, o_symbol_cnt 0,0,0,1,1,1, 2 GAP cycles, one o_done, o_busy 14 cycles.
REQ-039 Same, i_ready toggling 1,0 -> section durations double, o_sample_cnt holds on i_ready=0, total accepted samples 12.
REQ-040 size=0 -> o_data_frame never high; FCH end -> GAP -> o_done.
REQ-041 i_abort in DATA at o_symbol_cnt=1 -> IDLE next cycle, counters 0, no o_done; new i_start accepted next cycle.
REQ-042 i_reset_n low for one cycle mid-FCH -> outputs 0 immediately; i_start while busy and on reset release -> ignored.
REQ-043 GAP_LEN=0, size=1 -> o_done the cycle after last DATA sample accepted.
